// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH cycles,
// with registered sum/carry-out/overflow and a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic             cmsb;
    logic [CW-1:0]    cnt;

    logic fa_s;
    logic fa_co;

    assign fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_co = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    // NOTE: every register below is state, so only non-blocking assignments are used;
    // the shift registers are small flops (not a memory) and are cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        s_sr  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_PRE) begin
                        cmsb <= fa_co;
                    end
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, s_sr[WIDTH-1:1]};
                        cout  <= fa_co;
                        ovf   <= cmsb ^ fa_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes arithmetic expectations,
// an independent monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        int   total;
        total  = int'(x) + int'(y) + int'(c);
        e.sum  = W'(total);
        e.cout = (total >= (1 << W));
        e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: compares each done pulse against the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            check("done_not_consecutive", 32'(prev_done), 32'd0);
            check("busy_with_done", 32'(busy), 32'd1);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issues one add; with timed=1 it also checks the busy/done timeline edge by edge.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit timed);
        wait_idle();
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        q.push_back(model(x, y, c));
        @(posedge clk);
        #1 start = 1'b0;
        if (timed) begin
            for (int k = 0; k <= W + 1; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                check($sformatf("busy_e%0d", k), 32'(busy), 32'(k <= W));
                check($sformatf("done_e%0d", k), 32'(done), 32'(k == W));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic with full timeline on the first add.
        do_add(8'h3C, 8'h55, 1'b0, 1'b1);
        do_add(8'hFF, 8'h01, 1'b0, 1'b0);
        do_add(8'h80, 8'h80, 1'b0, 1'b0);
        do_add(8'h00, 8'h00, 1'b1, 1'b0);

        // Result hold across idle and a following RUN.
        do_add(8'h3C, 8'h55, 1'b0, 1'b0);
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            check("hold_idle_sum", 32'(sum), 32'h91);
        end
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        q.push_back(model(8'h01, 8'h01, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= W; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("hold_run_sum_e%0d", k), 32'(sum), (k < W) ? 32'h91 : 32'h02);
        end

        // Start held high: accepts every W+2 edges; operand churn during RUN/DONE is ignored.
        wait_idle();
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            q.push_back(model(a, b, cin));
            @(posedge clk);
            for (int k = 1; k <= W + 1; k++) begin
                @(negedge clk);
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                @(posedge clk);
            end
            #1 check("held_start_idle_gap", 32'(busy), 32'd0);
            @(negedge clk);
        end
        start = 1'b0;

        // Reset mid-operation: aborted add produces no done pulse.
        wait_idle();
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_sum", 32'(sum), 32'd0);
            check("abort_cout_ovf", 32'({cout, ovf}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_add(8'h12, 8'h34, 1'b0, 1'b1);

        // Random operands with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (2) @(negedge clk);
            check("scoreboard_drained", 32'(q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
